somador_datapath: RTL and testbench
===================================

Name: somador_datapath

Overview:
- Arithmetic datapath driven by the summation controller's strobes: `load`, `clear`, `transf`, `wren` and `ready`.
- Accumulates 32 input-RAM words in four groups of eight.
- Produces one group sum per `wren` for the output RAM, and holds a 4-entry result bank readable by the host.
- Sits between the input RAM's q port and the output RAM's data/address/we ports.

Parameters:
- DATA_W, 8, width of input RAM words.
- SUM_W, 11, accumulator and result width; 11 holds 8*255 without overflow.
- ADDR_W, 5, controller address width.
- GROUP, 8, terms per group.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  controller address; bits [4:3] give the group index.
- mem_q  input  DATA_W  input RAM read data, valid while the controller holds rden.
- load  input  1  capture mem_q into the operand register.
- clear  input  1  active-low accumulator clear.
- transf  input  1  add operand to accumulator.
- wren  input  1  commit accumulator as a group result.
- ready  input  1  controller end-of-frame pulse.
- rd_sel  input  2  result-bank read select.
- sum_data  output  SUM_W  registered write data to output RAM.
- sum_addr  output  2  registered write address to output RAM.
- sum_we  output  1  single-cycle write strobe to output RAM.
- rd_data  output  SUM_W  combinational read of bank[rd_sel].
- acc  output  SUM_W  current accumulator.
- term_count  output  4  terms accumulated since the last clear.
- overflow  output  1  sticky carry-out of the accumulator.
- seq_err  output  1  sticky protocol-error flag.
- frame_done  output  1  result-bank-complete flag.

Behaviour:
- Timing: controller strobes change on negedge clk; this block samples them on posedge. Each strobe is therefore seen for exactly one posedge per controller state, which is one clk period.
- Reset (synchronous, highest priority): clears operand, acc, term_count, overflow, seq_err, frame_done, sum_data, sum_addr, sum_we, wren_d, all four bank entries, and grp_written[3:0].
- Operand register: on load=1, operand <= mem_q, zero-extended to SUM_W.
- Accumulator update, priority after reset:
  1. clear=0: acc <= 0, term_count <= 0. overflow is not cleared.
  2. transf=1: acc <= acc + operand, truncated to SUM_W. If the carry out of bit SUM_W-1 is 1, overflow <= 1. term_count <= term_count + 1, saturating at 15.
  3. Otherwise: hold.
- load and transf in the same cycle: transf adds the old operand (register semantics).
- transf while term_count == GROUP: the add still happens, and seq_err <= 1.
- Write edge: wren_d is the one-cycle delayed wren. A write edge is wren=1 && wren_d=0. On a write edge:
  - sum_data <= acc, using the pre-update value if clear or transf is active in the same cycle.
  - sum_addr <= address[4:3].
  - sum_we <= 1 for exactly one cycle; otherwise sum_we <= 0.
  - bank[address[4:3]] <= acc; grp_written[address[4:3]] <= 1.
  - If term_count != GROUP, seq_err <= 1.
- wren held high for several cycles produces only one write.
- Result latency: accumulator value to sum_data/sum_we is 1 clk after the write edge. Bank update is the same cycle as sum_we; rd_data reflects it immediately after.
- ready=1 sampled:
  - If grp_written == 4'b1111: frame_done <= 1 and grp_written <= 0.
  - Otherwise: seq_err <= 1.
- frame_done clears on the next write edge to group 0, or on reset.
- Bank contents persist across frames until overwritten or reset.
- Reset mid-group: all partial sums are lost and the output is the reset state from the next cycle. Reset asserted together with wren: no write occurs.
- Width rule: acc wraps modulo 2^SUM_W; overflow records any wrap.

Test Plan:
- Reset, then for group 0 apply clear=0, then 8x (load with mem_q=k+1, transf) for k=0..7, then wren at address 7 -> sum_we one cycle later, sum_addr=0, sum_data=36, bank[0]=36, seq_err=0.
- Full frame with mem_q=255 for all 32 words (address 7,15,23,31 writes), then ready -> four writes of 2040, rd_data=2040 for rd_sel 0..3, frame_done=1, overflow=0.
- SUM_W=8, 8 terms of 200 -> acc=1600 mod 256=64, overflow=1; overflow stays 1 after clear=0.
- wren held 3 cycles; load+transf same cycle with old operand 5, new mem_q 9 -> exactly one sum_we pulse; acc increases by 5, then by 9 on the next transf.
- wren after only 6 transfs, and ready with grp_written=4'b0111 -> seq_err=1, frame_done=0.
- reset asserted mid-group after 4 transfs, simultaneous with wren -> no sum_we, acc=0, term_count=0, bank all 0.

Source files
------------

// File: rtl/somador_datapath.sv
// somador_datapath: arithmetic side of the summation engine.
// Captures input-RAM words, accumulates them in groups of GROUP terms,
// commits each group sum to the output RAM on the rising edge of wren,
// and keeps a four-entry result bank that the host can read at any time.
// Protocol slips (short groups, extra terms, incomplete frames) are
// recorded in a sticky seq_err flag rather than blocking the datapath.
module somador_datapath #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 11,
    parameter int ADDR_W = 5,
    parameter int GROUP  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              load,
    input  logic              clear,
    input  logic              transf,
    input  logic              wren,
    input  logic              ready,
    input  logic [1:0]        rd_sel,
    output logic [SUM_W-1:0]  sum_data,
    output logic [1:0]        sum_addr,
    output logic              sum_we,
    output logic [SUM_W-1:0]  rd_data,
    output logic [SUM_W-1:0]  acc,
    output logic [3:0]        term_count,
    output logic              overflow,
    output logic              seq_err,
    output logic              frame_done
);

    localparam logic [3:0] GROUP_CNT = 4'(GROUP);
    localparam logic [3:0] TERM_MAX  = 4'hF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] operand_q,    operand_d;
    logic [SUM_W-1:0] acc_q,        acc_d;
    logic [3:0]       term_q,       term_d;
    logic             overflow_q,   overflow_d;
    logic             seq_err_q,    seq_err_d;
    logic             frame_done_q, frame_done_d;
    logic [SUM_W-1:0] sum_data_q,   sum_data_d;
    logic [1:0]       sum_addr_q,   sum_addr_d;
    logic             sum_we_q,     sum_we_d;
    logic             wren_dly_q;
    logic [3:0]       grp_written_q, grp_written_d;

    // Bank read-out bus, one slice per group entry
    logic [3:0][SUM_W-1:0] bank_w;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic [1:0]     grp;
    logic           write_edge;
    logic           group_full;
    logic           bank_full;
    logic [SUM_W:0] sum_full;
    logic           unused_addr_bits;

    // Group index lives in the two top address bits; the word index is not needed here
    assign grp              = address[ADDR_W-1 -: 2];
    assign unused_addr_bits = ^address[ADDR_W-3:0];

    // Only the first cycle of a wren pulse commits, however long wren stays high
    assign write_edge = wren & ~wren_dly_q;
    assign group_full = (term_q == GROUP_CNT);
    assign bank_full  = &grp_written_q;

    // One extra bit keeps the carry out of the accumulator visible
    assign sum_full = {1'b0, acc_q} + {1'b0, operand_q};

    // Operand register: plain capture, so a same-cycle transf sees the old value
    always_comb begin
        operand_d = operand_q;
        if (load) begin
            operand_d = SUM_W'(mem_q);
        end
    end

    // Accumulator, term counter and carry tracking; clear (active low) beats transf
    always_comb begin
        acc_d      = acc_q;
        term_d     = term_q;
        overflow_d = overflow_q;
        if (!clear) begin
            acc_d  = '0;
            term_d = '0;
        end else if (transf) begin
            acc_d = sum_full[SUM_W-1:0];
            if (sum_full[SUM_W]) begin
                overflow_d = 1'b1;
            end
            term_d = (term_q == TERM_MAX) ? TERM_MAX : term_q + 4'd1;
        end
    end

    // Output-RAM write port: capture the pre-update accumulator on a write edge
    always_comb begin
        sum_data_d = sum_data_q;
        sum_addr_d = sum_addr_q;
        sum_we_d   = 1'b0;
        if (write_edge) begin
            sum_data_d = acc_q;
            sum_addr_d = grp;
            sum_we_d   = 1'b1;
        end
    end

    // Sticky protocol error: extra term, short group, or incomplete frame at ready
    always_comb begin
        seq_err_d = seq_err_q;
        if (clear && transf && group_full) begin
            seq_err_d = 1'b1;
        end
        if (write_edge && !group_full) begin
            seq_err_d = 1'b1;
        end
        if (ready && !bank_full) begin
            seq_err_d = 1'b1;
        end
    end

    // Frame bookkeeping: ready closes a full frame, a group-0 write opens the next one
    always_comb begin
        grp_written_d = grp_written_q;
        frame_done_d  = frame_done_q;
        if (write_edge && (grp == 2'd0)) begin
            frame_done_d = 1'b0;
        end
        if (ready && bank_full) begin
            frame_done_d  = 1'b1;
            grp_written_d = '0;
        end
        if (write_edge) begin
            grp_written_d[grp] = 1'b1;
        end
    end

    // Register update for everything except the bank entries
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_q     <= '0;
            acc_q         <= '0;
            term_q        <= '0;
            overflow_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            sum_data_q    <= '0;
            sum_addr_q    <= '0;
            sum_we_q      <= 1'b0;
            wren_dly_q    <= 1'b0;
            grp_written_q <= '0;
        end else begin
            operand_q     <= operand_d;
            acc_q         <= acc_d;
            term_q        <= term_d;
            overflow_q    <= overflow_d;
            seq_err_q     <= seq_err_d;
            frame_done_q  <= frame_done_d;
            sum_data_q    <= sum_data_d;
            sum_addr_q    <= sum_addr_d;
            sum_we_q      <= sum_we_d;
            wren_dly_q    <= wren;
            grp_written_q <= grp_written_d;
        end
    end

    // ------------------------------------------------------------------
    // Result bank: one register per group, written alongside sum_we
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic [SUM_W-1:0] entry_q;
        logic             entry_we;

        assign entry_we = write_edge && (grp == 2'(gi));

        // Entry holds its group sum until the group is rewritten or reset
        always_ff @(posedge clk) begin
            if (reset) begin
                entry_q <= '0;
            end else if (entry_we) begin
                entry_q <= acc_q;
            end
        end

        assign bank_w[gi] = entry_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data    = bank_w[rd_sel];
    assign sum_data   = sum_data_q;
    assign sum_addr   = sum_addr_q;
    assign sum_we     = sum_we_q;
    assign acc        = acc_q;
    assign term_count = term_q;
    assign overflow   = overflow_q;
    assign seq_err    = seq_err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_somador_datapath.sv
// Bench for somador_datapath: two instances (SUM_W=11 and SUM_W=8) share
// one stimulus stream; a behavioural model is checked against both every
// cycle, and directed scenarios pin the model with literal expectations.
module tb_somador_datapath;

    localparam int G = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       load = 1'b0, clear = 1'b1, transf = 1'b0, wren = 1'b0, ready = 1'b0;
    logic [4:0] address = '0;
    logic [7:0] mem_q = '0;
    logic [1:0] rd_sel = '0;

    logic [10:0] a_sum_data, a_rd_data, a_acc;
    logic [1:0]  a_sum_addr;
    logic        a_sum_we, a_ovf, a_serr, a_fd;
    logic [3:0]  a_tc;

    logic [7:0]  b_sum_data, b_rd_data, b_acc;
    logic [1:0]  b_sum_addr;
    logic        b_sum_we, b_ovf, b_serr, b_fd;
    logic [3:0]  b_tc;

    somador_datapath #(.DATA_W(8), .SUM_W(11), .ADDR_W(5), .GROUP(8)) dut_a (
        .clk(clk), .reset(reset), .address(address), .mem_q(mem_q),
        .load(load), .clear(clear), .transf(transf), .wren(wren), .ready(ready),
        .rd_sel(rd_sel), .sum_data(a_sum_data), .sum_addr(a_sum_addr),
        .sum_we(a_sum_we), .rd_data(a_rd_data), .acc(a_acc), .term_count(a_tc),
        .overflow(a_ovf), .seq_err(a_serr), .frame_done(a_fd)
    );

    somador_datapath #(.DATA_W(8), .SUM_W(8), .ADDR_W(5), .GROUP(8)) dut_b (
        .clk(clk), .reset(reset), .address(address), .mem_q(mem_q),
        .load(load), .clear(clear), .transf(transf), .wren(wren), .ready(ready),
        .rd_sel(rd_sel), .sum_data(b_sum_data), .sum_addr(b_sum_addr),
        .sum_we(b_sum_we), .rd_data(b_rd_data), .acc(b_acc), .term_count(b_tc),
        .overflow(b_ovf), .seq_err(b_serr), .frame_done(b_fd)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (index 0: 11-bit, 1: 8-bit) ----------------
    int  m_op[2], m_acc[2], m_tc[2], m_ovf[2], m_serr[2], m_fd[2];
    int  m_sd[2], m_sa[2], m_we[2], m_gw[2], m_wd[2];
    int  m_bank[2][4];
    bit  started = 0;

    function automatic int modmask(input int i);
        return (i == 0) ? 2047 : 255;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_op[i] = 0; m_acc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_serr[i] = 0;
                m_fd[i] = 0; m_sd[i] = 0; m_sa[i] = 0; m_we[i] = 0; m_gw[i] = 0; m_wd[i] = 0;
                for (int k = 0; k < 4; k++) m_bank[i][k] = 0;
                started = 1;
            end else begin
                int old_acc, old_tc, old_op, old_gw, g, s;
                bit wedge;
                old_acc = m_acc[i]; old_tc = m_tc[i]; old_op = m_op[i]; old_gw = m_gw[i];
                g = int'(address) / 8;
                wedge = wren && (m_wd[i] == 0);
                if (load) m_op[i] = int'(mem_q);
                if (!clear) begin
                    m_acc[i] = 0; m_tc[i] = 0;
                end else if (transf) begin
                    s = old_acc + old_op;
                    if (s > modmask(i)) m_ovf[i] = 1;
                    m_acc[i] = s % (modmask(i) + 1);
                    if (old_tc == G) m_serr[i] = 1;
                    m_tc[i] = (old_tc >= 15) ? 15 : old_tc + 1;
                end
                m_we[i] = wedge ? 1 : 0;
                if (wedge) begin
                    m_sd[i] = old_acc; m_sa[i] = g; m_bank[i][g] = old_acc;
                    if (old_tc != G) m_serr[i] = 1;
                    if (g == 0) m_fd[i] = 0;
                end
                if (ready) begin
                    if (old_gw == 15) begin m_fd[i] = 1; m_gw[i] = 0; end
                    else m_serr[i] = 1;
                end
                if (wedge) m_gw[i] = m_gw[i] | (1 << g);
                m_wd[i] = wren ? 1 : 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("a_acc",      int'(a_acc),      m_acc[0]);
        chk("a_term",     int'(a_tc),       m_tc[0]);
        chk("a_overflow", int'(a_ovf),      m_ovf[0]);
        chk("a_seq_err",  int'(a_serr),     m_serr[0]);
        chk("a_frame",    int'(a_fd),       m_fd[0]);
        chk("a_sum_we",   int'(a_sum_we),   m_we[0]);
        chk("a_sum_data", int'(a_sum_data), m_sd[0]);
        chk("a_sum_addr", int'(a_sum_addr), m_sa[0]);
        chk("a_rd_data",  int'(a_rd_data),  m_bank[0][rd_sel]);
        chk("b_acc",      int'(b_acc),      m_acc[1]);
        chk("b_term",     int'(b_tc),       m_tc[1]);
        chk("b_overflow", int'(b_ovf),      m_ovf[1]);
        chk("b_seq_err",  int'(b_serr),     m_serr[1]);
        chk("b_frame",    int'(b_fd),       m_fd[1]);
        chk("b_sum_we",   int'(b_sum_we),   m_we[1]);
        chk("b_sum_data", int'(b_sum_data), m_sd[1]);
        chk("b_sum_addr", int'(b_sum_addr), m_sa[1]);
        chk("b_rd_data",  int'(b_rd_data),  m_bank[1][rd_sel]);
    endtask

    // Model advances on each posedge; outputs are compared 1 time unit later
    always @(posedge clk) begin
        model_step();
        #1;
        if (started) compare_all();
    end

    // ---------------- stimulus helpers (inputs change on negedge) ----------------
    int grp_vals[8];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 0; clear = 1; transf = 0; wren = 0; ready = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_group(input int g, input int nterms);
        clear = 1'b0; tick(); clear = 1'b1;
        for (int k = 0; k < nterms; k++) begin
            load = 1'b1; mem_q = 8'(grp_vals[k]); tick();
            load = 1'b0; transf = 1'b1; tick();
            transf = 1'b0;
        end
        address = 5'(g * 8 + 7); wren = 1'b1; tick();
        wren = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < 8; k++) grp_vals[k] = v;
    endtask

    initial begin
        int pulses;
        tick();
        do_reset();
        chk("reset_acc", int'(a_acc), 0);
        chk("reset_we",  int'(a_sum_we), 0);

        // Group 0 with terms 1..8
        for (int k = 0; k < 8; k++) grp_vals[k] = k + 1;
        run_group(0, 8);
        chk("g0_we",   int'(a_sum_we), 1);
        chk("g0_addr", int'(a_sum_addr), 0);
        chk("g0_data", int'(a_sum_data), 36);
        chk("g0_bank", int'(a_rd_data), 36);
        chk("g0_serr", int'(a_serr), 0);

        // Full frame of 255s
        fill(255);
        for (int g = 0; g < 4; g++) begin
            run_group(g, 8);
            chk("frame_sum", int'(a_sum_data), 2040);
            chk("frame_addr", int'(a_sum_addr), g);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        chk("frame_done", int'(a_fd), 1);
        chk("frame_ovf",  int'(a_ovf), 0);
        chk("frame_serr", int'(a_serr), 0);
        chk("small_ovf",  int'(b_ovf), 1);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            chk("frame_rd", int'(a_rd_data), 2040);
        end
        rd_sel = 2'd0;
        run_group(0, 8);
        chk("frame_done_clr", int'(a_fd), 0);

        // 8 x 200 wraps the 8-bit instance
        do_reset();
        fill(200);
        run_group(0, 8);
        chk("wrap_acc",   int'(b_acc), 64);
        chk("wrap_ovf",   int'(b_ovf), 1);
        chk("wrap_data",  int'(b_sum_data), 64);
        chk("wide_acc",   int'(a_acc), 1600);
        clear = 1'b0; tick(); clear = 1'b1;
        chk("ovf_sticky", int'(b_ovf), 1);
        chk("clr_acc",    int'(b_acc), 0);

        // load+transf overlap, then wren held three cycles
        do_reset();
        clear = 1'b0; tick(); clear = 1'b1;
        load = 1'b1; mem_q = 8'd5; tick();
        mem_q = 8'd9; transf = 1'b1; tick();
        chk("old_operand", int'(a_acc), 5);
        load = 1'b0; tick();
        chk("new_operand", int'(a_acc), 14);
        transf = 1'b0; address = 5'd7; wren = 1'b1;
        pulses = 0;
        repeat (3) begin tick(); pulses += int'(a_sum_we); end
        wren = 1'b0; tick(); pulses += int'(a_sum_we);
        chk("one_pulse", pulses, 1);
        chk("short_serr", int'(a_serr), 1);

        // Short group and incomplete frame
        do_reset();
        for (int k = 0; k < 8; k++) grp_vals[k] = int'($urandom_range(0, 255));
        run_group(0, 8);
        run_group(1, 8);
        chk("pre_serr", int'(a_serr), 0);
        run_group(2, 6);
        chk("six_serr", int'(a_serr), 1);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("partial_fd", int'(a_fd), 0);

        // Reset mid-group together with wren
        clear = 1'b0; tick(); clear = 1'b1;
        fill(10);
        for (int k = 0; k < 4; k++) begin
            load = 1'b1; mem_q = 8'd10; tick();
            load = 1'b0; transf = 1'b1; tick(); transf = 1'b0;
        end
        chk("mid_acc", int'(a_acc), 40);
        reset = 1'b1; wren = 1'b1; address = 5'd7; tick();
        reset = 1'b0; wren = 1'b0;
        chk("rst_we",   int'(a_sum_we), 0);
        chk("rst_acc",  int'(a_acc), 0);
        chk("rst_term", int'(a_tc), 0);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s); #1;
            chk("rst_bank", int'(a_rd_data), 0);
        end

        // Randomised frames followed by free-running random strobes
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int g = 0; g < 4; g++) begin
                for (int k = 0; k < 8; k++) grp_vals[k] = int'($urandom_range(0, 255));
                rd_sel = 2'($urandom);
                run_group(g, 8);
            end
            ready = 1'b1; tick(); ready = 1'b0;
        end
        for (int c = 0; c < 1500; c++) begin
            reset   = ($urandom_range(0, 99) < 2);
            load    = 1'($urandom_range(0, 1));
            clear   = ($urandom_range(0, 9) != 0);
            transf  = 1'($urandom_range(0, 1));
            wren    = ($urandom_range(0, 5) == 0);
            ready   = ($urandom_range(0, 19) == 0);
            address = 5'($urandom);
            mem_q   = 8'($urandom);
            rd_sel  = 2'($urandom);
            tick();
        end
        reset = 0; load = 0; clear = 1; transf = 0; wren = 0; ready = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
